serial_adder_nbit: RTL and testbench
====================================

Name: serial_adder_nbit

Overview:
Multi-cycle, parametrised add/subtract unit that reuses a DIGIT-bit ripple slice of full-adder cells over WIDTH/DIGIT clock cycles, LSB digit first. It is the area-reduced successor of the single-cell full adder. It adds a start/busy/done handshake, a subtract mode and signed-overflow reporting. It sits beside the combinational adder datapath wherever latency can be traded for area.

Parameters:
WIDTH, 8, operand and result width in bits
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly, 1 <= DIGIT <= WIDTH

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on the rising edge only when not busy
sub  input  1  0 = a + b + ci; 1 = a - b (a + ~b + 1, ci ignored); sampled with start
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
ci  input  1  carry in for add mode, sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: S/cout/overflow updated this cycle
S  output  WIDTH  registered result
cout  output  1  carry out of MSB (sub mode: 1 = no borrow)
overflow  output  1  two's-complement overflow of the last result

Behaviour:
- Clock and reset: one clock domain (clk); rst is asynchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, S=0, cout=0, overflow=0, and all internal registers cleared. Reset takes effect immediately, independent of clk.
- NSTEPS = WIDTH/DIGIT.
- States:
  - IDLE: busy=0. On start=1, latch a, sub ? ~b : b, carry = sub ? 1 : ci, sub; clear step counter; go to RUN.
  - RUN: busy=1. Each cycle, the DIGIT-bit slice adds the low DIGIT bits of the A/B shift registers with the carry register. The sum digit is shifted into the result shift register from the top, and A/B shift right by DIGIT. The carry register takes the slice carry. The MSB carry-in of the slice is kept for the overflow computation. The counter increments. On the edge where the counter reaches NSTEPS-1, transfer the result to S, the carry to cout, and overflow = carry_into_MSB XOR carry_out_of_MSB; go to DONE.
  - DONE: done=1, busy=0. On start=1, latch the new operands and go directly to RUN (back-to-back). Otherwise go to IDLE.
- Latency: start sampled at edge E0; done is high in the cycle following edge E(NSTEPS). This is NSTEPS+1 cycles from the start cycle to the done cycle. Throughput is one result per NSTEPS+1 cycles.
- S, cout and overflow change only on the completion edge. They hold their previous values throughout RUN and until the next completion.
- start while busy=1 is ignored; there is no queueing. a, b, ci and sub may change freely during RUN.
- DIGIT=WIDTH gives NSTEPS=1: one RUN cycle, then DONE.
- Reset asserted mid-RUN aborts the operation: no done pulse, and outputs are cleared to 0.
- Arithmetic is modulo 2^WIDTH. The carry leaves the result only through cout.

Decomposition:
- Package serial_adder_pkg: state enum (IDLE, RUN, DONE); function to derive NSTEPS and the counter width (clog2 of NSTEPS, minimum 1).
- One sub-module, digit_adder: combinational DIGIT-bit ripple chain of full-adder cells. Inputs are a_d, b_d and cin. Outputs are s_d, cout and c_msb_in (the carry into the top cell).

Test Plan:
- WIDTH=8, DIGIT=1, add: a=0x5A, b=0x3C, ci=0 -> done 9 cycles after start; S=0x96, cout=0, overflow=1; busy high exactly 8 cycles.
- Add wrap: a=0xFF, b=0x01, ci=0 -> S=0x00, cout=1, overflow=0. Then a=0x00, b=0x00, ci=1 -> S=0x01, cout=0.
- Subtract: a=0x10, b=0x20, sub=1 -> S=0xF0, cout=0, overflow=0. Then a=0x80, b=0x01, sub=1 -> S=0x7F, cout=1, overflow=1.
- Handshake: start held high through RUN -> no restart mid-operation. start=1 in the DONE cycle with a=0x01, b=0x02 -> next done 9 cycles later with S=0x03. S holds the previous result during RUN.
- Reset: assert rst at RUN step 4 -> busy, done, S, cout and overflow go to 0 immediately, with no done pulse. After release, a new start completes normally.
- WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001 -> done 5 cycles after start; S=0x0000, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial add/subtract unit.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int calc_nsteps(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-step configuration still needs a one-bit counter to stay well-formed.
    function automatic int calc_cnt_width(input int nsteps);
        return (nsteps <= 1) ? 1 : $clog2(nsteps);
    endfunction

endpackage

// File: rtl/serial_adder_nbit_digit_adder.sv
// Combinational DIGIT-bit ripple chain of full-adder cells; exposes the carry
// into the top cell so the caller can derive signed overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s_d  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
            c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
        end
    end

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_nbit.sv
// Multi-cycle add/subtract unit: one DIGIT-bit slice reused over WIDTH/DIGIT
// cycles, LSB digit first, with start/busy/done handshake and overflow flag.
module serial_adder_nbit
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             overflow
);

    localparam int NSTEPS = calc_nsteps(WIDTH, DIGIT);
    localparam int CNT_W  = calc_cnt_width(NSTEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEPS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d, s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;

    digit_adder #(.DIGIT(DIGIT)) u_slice (
        .a_d      (a_q[DIGIT-1:0]),
        .b_d      (b_q[DIGIT-1:0]),
        .cin      (carry_q),
        .s_d      (slice_sum),
        .cout     (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            RUN: begin
                // Sum digits enter at the top so the LSB digit ends up at bit 0.
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = (WIDTH'(slice_sum) << (WIDTH - DIGIT)) | (res_q >> DIGIT);
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    s_d     = res_d;
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        // Subtraction is a + ~b + 1, so only the inverted operand and carry are latched.
        if (start && (state_q != RUN)) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : ci;
            res_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign S        = s_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Self-checking bench: per-cycle comparison against an arithmetic reference
// model for an 8x1 instance, plus directed and random checks on a 16x4 instance.
module tb_serial_adder_nbit;

    localparam int NS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub, ci;
    logic [7:0]  a, b;
    logic        busy, done, cout, overflow;
    logic [7:0]  S;

    logic        start2, sub2, ci2;
    logic [15:0] a2, b2;
    logic        busy2, done2, cout2, ovf2;
    logic [15:0] S2;

    int checks = 0;
    int fails  = 0;
    bit cmpEn  = 0;

    always #5 clk = ~clk;

    serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .S(S), .cout(cout), .overflow(overflow)
    );

    serial_adder_nbit #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2), .ci(ci2),
        .busy(busy2), .done(done2), .S(S2), .cout(cout2), .overflow(ovf2)
    );

    // Returns {cout, overflow, result} from plain integer arithmetic.
    function automatic logic [17:0] refOp(input int width, input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        longint mask, half, xv, yv, cv, sum, sx, sy, tv;
        logic co, ov;
        mask = (longint'(1) << width) - 1;
        half = longint'(1) << (width - 1);
        xv   = longint'(x) & mask;
        yv   = (s ? longint'(~y) : longint'(y)) & mask;
        cv   = s ? 1 : longint'(c);
        sum  = xv + yv + cv;
        co   = ((sum >> width) & 1) != 0;
        sx   = (xv >= half) ? xv - 2 * half : xv;
        sy   = (yv >= half) ? yv - 2 * half : yv;
        tv   = sx + sy + cv;
        ov   = (tv >= half) || (tv < -half);
        return {co, ov, 16'(sum & mask)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model of the 8-bit instance: pending result commits after NS run cycles.
    int          mRemain = 0;
    bit          mDone   = 0;
    logic [7:0]  mS = '0, pS = '0;
    logic        mCout = 0, mOvf = 0, pCout = 0, pOvf = 0;
    logic [17:0] mR;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mRemain <= 0; mDone <= 0; mS <= '0; mCout <= 0; mOvf <= 0;
        end else if (mRemain > 0) begin
            mRemain <= mRemain - 1;
            if (mRemain == 1) begin
                mS <= pS; mCout <= pCout; mOvf <= pOvf; mDone <= 1;
            end
        end else if (start) begin
            mR = refOp(8, {8'h00, a}, {8'h00, b}, ci, sub);
            pS <= mR[7:0]; pCout <= mR[17]; pOvf <= mR[16];
            mRemain <= NS; mDone <= 0;
        end else begin
            mDone <= 0;
        end
    end

    always @(negedge clk) begin
        if (cmpEn && !rst)
            checkOutput("cycle busy/done/cout/ovf/S", 32'({busy, done, cout, overflow, S}),
                        32'({mRemain > 0, mDone, mCout, mOvf, mS}));
    end

    // Called at a negedge with start already driven; returns at the negedge where done is seen.
    task automatic waitDone(input string tag, input int expLat, input bit holdStart,
                            input logic [7:0] nextA, input logic [7:0] nextB);
        int lat = 0;
        int bc  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                if (holdStart) begin
                    a = nextA; b = nextB; ci = 1'b0; sub = 1'b0;
                end else begin
                    start = 1'b0;
                    a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
                end
            end
            if (busy) bc++;
        end while (!done && lat < 40);
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " busy cycles"}, 32'(bc), 32'(expLat - 1));
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] x, input logic [7:0] y,
                                 input logic c, input logic s,
                                 input logic [7:0] eS, input logic eC, input logic eO);
        a = x; b = y; ci = c; sub = s; start = 1'b1;
        waitDone(tag, NS + 1, 1'b0, 8'h00, 8'h00);
        checkOutput({tag, " S"}, 32'(S), 32'(eS));
        checkOutput({tag, " cout"}, 32'(cout), 32'(eC));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(eO));
    endtask

    task automatic applyWide(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic c, input logic s);
        logic [17:0] e;
        int lat = 0;
        e = refOp(16, x, y, c, s);
        a2 = x; b2 = y; ci2 = c; sub2 = s; start2 = 1'b1;
        do begin
            @(negedge clk);
            start2 = 1'b0;
            lat++;
        end while (!done2 && lat < 40);
        checkOutput({tag, " latency"}, 32'(lat), 32'd5);
        checkOutput({tag, " result"}, 32'({cout2, ovf2, S2}), 32'(e));
    endtask

    initial begin
        logic [7:0] rx, ry;
        logic       rc, rs;
        logic [17:0] e;
        rst = 1'b1; start = 0; sub = 0; ci = 0; a = '0; b = '0;
        start2 = 0; sub2 = 0; ci2 = 0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset state w8", 32'({busy, done, cout, overflow, S}), 32'h0);
        checkOutput("reset state w16", 32'({busy2, done2, cout2, ovf2, S2}), 32'h0);

        checkOutput("model pin add", 32'(refOp(8, 16'h005A, 16'h003C, 1'b0, 1'b0)), 32'({2'b01, 16'h0096}));
        checkOutput("model pin sub", 32'(refOp(8, 16'h0080, 16'h0001, 1'b0, 1'b1)), 32'({2'b11, 16'h007F}));
        checkOutput("model pin w16", 32'(refOp(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'({2'b10, 16'h0000}));

        rst = 1'b0;
        cmpEn = 1;
        @(negedge clk);

        applyStimulus("add 5A+3C", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        applyStimulus("add FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus("add ci",    8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        applyStimulus("sub 10-20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        applyStimulus("sub 80-01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start held through the run; the DONE-cycle start launches 01+02 back-to-back.
        a = 8'h11; b = 8'h22; ci = 0; sub = 0; start = 1'b1;
        waitDone("hold first", NS + 1, 1'b1, 8'h01, 8'h02);
        checkOutput("hold first S", 32'(S), 32'h33);
        waitDone("back-to-back", NS + 1, 1'b0, 8'h00, 8'h00);
        checkOutput("back-to-back S", 32'(S), 32'h03);

        // Abort mid-run with a nonzero previous result on S.
        applyStimulus("pre-reset", 8'h40, 8'h41, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1);
        a = 8'h5A; b = 8'h3C; ci = 0; sub = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("async reset outputs", 32'({busy, done, cout, overflow, S}), 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("no done during reset", 32'({busy, done}), 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        applyStimulus("after reset", 8'h21, 8'h12, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            rx = 8'($urandom); ry = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            e = refOp(8, {8'h00, rx}, {8'h00, ry}, rc, rs);
            a = rx; b = ry; ci = rc; sub = rs; start = 1'b1;
            waitDone("random op", NS + 1, 1'b0, 8'h00, 8'h00);
            checkOutput("random result", 32'({cout, overflow, S}), 32'({e[17], e[16], e[7:0]}));
        end

        applyWide("w16 FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("w16 wrap S", 32'(S2), 32'h0);
        checkOutput("w16 wrap cout", 32'(cout2), 32'h1);
        applyWide("w16 sub", 16'h8000, 16'h0001, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++)
            applyWide("w16 random", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
